// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and geometry for the 4x4 key matrix scanner
package kbd_pkg;
    typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W = 4;
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1000;
endpackage

// File: rtl/kbd_scan_4x4_if.sv
// kbd_scan_4x4_if: key report handshake between scanner (master) and consumer (slave)
interface kbd_scan_4x4_if;
    import kbd_pkg::*;
    logic [KEY_W-1:0] key_code;
    logic key_valid;
    logic key_ack;
    logic key_down;
    logic overrun;
    modport master(output key_code, key_valid, key_down, overrun, input key_ack);
    modport slave(input key_code, key_valid, key_down, overrun, output key_ack);
endinterface

// File: rtl/kbd_row_sync.sv
// kbd_row_sync: two-flop synchroniser for the asynchronous row returns
module kbd_row_sync
    import kbd_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_ROWS-1:0] i_d,
    output logic [NUM_ROWS-1:0] o_q
);
    logic [NUM_ROWS-1:0] r_s1, r_s2;

    // metastability filter: two back-to-back flops
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end

    assign o_q = r_s2;
endmodule

// File: rtl/kbd_scan_4x4.sv
// kbd_scan_4x4: column scanner, frame debouncer and single-key reporter
module kbd_scan_4x4
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                nrst,
    output logic [NUM_COLS-1:0] col,
    input  logic [NUM_ROWS-1:0] row,
    kbd_scan_4x4_if.master      kbd
);
    localparam int NK = NUM_COLS * NUM_ROWS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam bit ONE_SHOT = (DEBOUNCE == 1);

    logic [DW-1:0]       r_div;
    logic [NUM_COLS-1:0] r_col;
    logic [NK-1:0]       r_snap;
    state_t              r_state;
    logic [KEY_W-1:0]    r_cand, r_code;
    logic [CW-1:0]       r_cnt, r_rel;
    logic                r_valid, r_down, r_ovr;

    logic [NUM_ROWS-1:0] w_row;
    logic                w_tick, w_done, w_single, w_none, w_accept;
    logic [1:0]          w_idx;
    logic [NK-1:0]       w_frame;
    logic [KEY_W-1:0]    w_key;
    logic [KEY_W:0]      w_n;
    logic [CW-1:0]       w_cnt_nx, w_rel_nx;

    kbd_row_sync u_sync (.clk(clk), .nrst(nrst), .i_d(row), .o_q(w_row));

    assign w_tick   = r_div == DW'(SCAN_DIV - 1);
    assign w_done   = w_tick && r_col[0];
    assign w_frame  = r_snap | {{(NK-NUM_ROWS){1'b0}}, w_row};
    assign w_single = w_n == (KEY_W+1)'(1);
    assign w_none   = w_n == '0;
    assign w_cnt_nx = r_cnt + 1'b1;
    assign w_rel_nx = r_rel + 1'b1;
    assign w_accept = w_done && w_single && ((r_state == IDLE && ONE_SHOT) ||
                      (r_state == DEB && w_key == r_cand && w_cnt_nx == CW'(DEBOUNCE)));

    // column index of the one-hot strobe (bit n -> index n)
    always_comb w_idx = r_col[3] ? 2'd3 : r_col[2] ? 2'd2 : r_col[1] ? 2'd1 : 2'd0;

    // classify the completed frame: population count and code of the highest set key
    always_comb begin
        w_key = '0;
        for (int i = 0; i < NK; i++)
            if (w_frame[i]) w_key = KEY_W'(i);
        w_n = (KEY_W+1)'($countones(w_frame));
    end

    // dwell divider, rotating column strobe and frame snapshot
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            r_div  <= '0;
            r_col  <= COL_RESET;
            r_snap <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_col  <= r_col[0] ? COL_RESET : r_col >> 1;
                r_snap <= r_col[0] ? '0 : r_snap | (NK'(w_row) << {w_idx, 2'b00});
            end
        end

    // debounce FSM and handshake; an accept overrides a same-cycle ack so the new key wins
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_rel   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (kbd.key_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_done)
                case (r_state)
                    IDLE: if (w_single) begin
                        r_cand  <= w_key;
                        r_cnt   <= CW'(1);
                        r_state <= DEB;
                    end
                    DEB: if (!w_single) r_state <= IDLE;
                         else if (w_key == r_cand) r_cnt <= w_cnt_nx;
                         else begin
                             r_cand <= w_key;
                             r_cnt  <= CW'(1);
                         end
                    HELD: if (!w_none) r_rel <= '0;
                          else if (w_rel_nx == CW'(DEBOUNCE)) begin
                              r_state <= IDLE;
                              r_down  <= 1'b0;
                          end else r_rel <= w_rel_nx;
                    default: r_state <= IDLE;
                endcase
            if (w_accept) begin
                r_state <= HELD;
                r_down  <= 1'b1;
                r_rel   <= '0;
                if (!r_valid || kbd.key_ack) begin
                    r_code  <= w_key;
                    r_valid <= 1'b1;
                end else r_ovr <= 1'b1;
            end
        end

    assign col           = r_col;
    assign kbd.key_code  = r_code;
    assign kbd.key_valid = r_valid;
    assign kbd.key_down  = r_down;
    assign kbd.overrun   = r_ovr;
endmodule

// File: tb/tb_kbd_scan_4x4.sv
// tb_kbd_scan_4x4: directed bench with a simple key-matrix model (SCAN_DIV=4, DEBOUNCE=2)
module tb_kbd_scan_4x4;
    localparam int FR = 16;
    localparam logic [15:0] K9 = 16'h0200;
    localparam logic [15:0] K0 = 16'h0001;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  col, row;
    logic [15:0] keys = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    kbd_scan_4x4_if u_if ();

    kbd_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE(2)) u_dut (
        .clk(clk), .nrst(nrst), .col(col), .row(row), .kbd(u_if)
    );

    always #5 clk = ~clk;

    assign row = col[3] ? keys[15:12] : col[2] ? keys[11:8] : col[1] ? keys[7:4] : keys[3:0];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic align();
        step((FR - cyc % FR) % FR);
    endtask

    task automatic ack_pulse();
        u_if.key_ack = 1'b1;
        step(1);
        u_if.key_ack = 1'b0;
    endtask

    task automatic release_nrst();
        @(negedge clk);
        nrst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [3:0] exp_col;
        u_if.key_ack = 1'b0;
        repeat (2) @(posedge clk);
        release_nrst();
        chk("rst_valid", 16'(u_if.key_valid), 16'd0);
        chk("rst_code", 16'(u_if.key_code), 16'd0);
        chk("rst_down", 16'(u_if.key_down), 16'd0);
        chk("rst_ovr", 16'(u_if.overrun), 16'd0);
        for (int i = 0; i < 20; i++) begin
            exp_col = 4'b1000 >> ((i / 4) % 4);
            chk($sformatf("col_%0d", i), 16'(col), 16'(exp_col));
            step(1);
        end
        chk("scan_valid", 16'(u_if.key_valid), 16'd0);
        align();

        keys = K9;
        step(FR);
        chk("p9_f1_valid", 16'(u_if.key_valid), 16'd0);
        step(FR);
        chk("p9_valid", 16'(u_if.key_valid), 16'd1);
        chk("p9_code", 16'(u_if.key_code), 16'd9);
        chk("p9_down", 16'(u_if.key_down), 16'd1);
        chk("p9_ovr", 16'(u_if.overrun), 16'd0);
        ack_pulse();
        chk("ack_valid", 16'(u_if.key_valid), 16'd0);
        chk("ack_down", 16'(u_if.key_down), 16'd1);
        keys = '0;
        align();
        chk("rel_f1_down", 16'(u_if.key_down), 16'd1);
        step(FR);
        chk("rel_f2_down", 16'(u_if.key_down), 16'd0);

        keys = K9;
        step(FR);
        chk("bnc_f1_valid", 16'(u_if.key_valid), 16'd0);
        keys = '0;
        step(FR);
        chk("bnc_f2_valid", 16'(u_if.key_valid), 16'd0);
        chk("bnc_f2_down", 16'(u_if.key_down), 16'd0);
        keys = K9;
        step(FR);
        chk("bnc_re_f1_valid", 16'(u_if.key_valid), 16'd0);
        step(FR);
        chk("bnc_re_valid", 16'(u_if.key_valid), 16'd1);
        chk("bnc_re_code", 16'(u_if.key_code), 16'd9);
        ack_pulse();
        keys = '0;
        align();
        step(FR);
        chk("bnc_rel_down", 16'(u_if.key_down), 16'd0);

        keys = K9 | K0;
        step(3 * FR);
        chk("multi_valid", 16'(u_if.key_valid), 16'd0);
        chk("multi_down", 16'(u_if.key_down), 16'd0);
        keys = K9;
        step(FR);
        chk("multi_to9_f1", 16'(u_if.key_valid), 16'd0);
        step(FR);
        chk("multi_to9_valid", 16'(u_if.key_valid), 16'd1);
        chk("multi_to9_code", 16'(u_if.key_code), 16'd9);
        ack_pulse();
        keys = K9 | K0;
        align();
        step(2 * FR);
        chk("held_multi_down", 16'(u_if.key_down), 16'd1);
        chk("held_multi_valid", 16'(u_if.key_valid), 16'd0);
        keys = '0;
        step(FR);
        chk("held_rel_f1", 16'(u_if.key_down), 16'd1);
        step(FR);
        chk("held_rel_f2", 16'(u_if.key_down), 16'd0);

        keys = K9;
        step(2 * FR);
        chk("ovr_p9_valid", 16'(u_if.key_valid), 16'd1);
        keys = '0;
        step(2 * FR);
        chk("ovr_rel_down", 16'(u_if.key_down), 16'd0);
        chk("ovr_rel_valid", 16'(u_if.key_valid), 16'd1);
        keys = K0;
        step(2 * FR);
        chk("ovr_down", 16'(u_if.key_down), 16'd1);
        chk("ovr_code", 16'(u_if.key_code), 16'd9);
        chk("ovr_valid", 16'(u_if.key_valid), 16'd1);
        chk("ovr_flag", 16'(u_if.overrun), 16'd1);
        ack_pulse();
        chk("ovr_ack_valid", 16'(u_if.key_valid), 16'd0);
        chk("ovr_ack_flag", 16'(u_if.overrun), 16'd0);
        keys = '0;
        align();
        step(FR);
        chk("ovr_k0_rel", 16'(u_if.key_down), 16'd0);

        keys = K9;
        step(2 * FR);
        keys = '0;
        step(2 * FR);
        keys = K0;
        step(2 * FR - 1);
        chk("same_pre_code", 16'(u_if.key_code), 16'd9);
        u_if.key_ack = 1'b1;
        step(1);
        u_if.key_ack = 1'b0;
        chk("same_valid", 16'(u_if.key_valid), 16'd1);
        chk("same_code", 16'(u_if.key_code), 16'd0);
        chk("same_ovr", 16'(u_if.overrun), 16'd0);
        ack_pulse();
        keys = '0;
        align();
        step(FR);

        keys = K9;
        step(2 * FR);
        keys = '0;
        step(2 * FR);
        keys = K9;
        step(FR + 5);
        chk("pre_rst_col", 16'(col), 16'b0100);
        chk("pre_rst_code", 16'(u_if.key_code), 16'd9);
        nrst = 1'b0;
        #1;
        chk("mid_rst_col", 16'(col), 16'b1000);
        chk("mid_rst_valid", 16'(u_if.key_valid), 16'd0);
        chk("mid_rst_code", 16'(u_if.key_code), 16'd0);
        chk("mid_rst_down", 16'(u_if.key_down), 16'd0);
        chk("mid_rst_ovr", 16'(u_if.overrun), 16'd0);
        release_nrst();
        step(FR);
        chk("post_rst_f1", 16'(u_if.key_valid), 16'd0);
        step(FR);
        chk("post_rst_valid", 16'(u_if.key_valid), 16'd1);
        chk("post_rst_code", 16'(u_if.key_code), 16'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/kbd_scan_4x4.md
Name: kbd_scan_4x4

Overview:
- Scans a 4x4 key matrix: drives one-hot column strobes, samples row returns, debounces, reports single key presses to the CPU-side logic through a valid/ack handshake.
- Input-side counterpart of the multiplexed 4-digit display driver on the same front panel. Uses the same one-hot rotating select scheme, starting at the MSB and shifting right.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven (dwell); must be >= 2.
- DEBOUNCE, 4: consecutive identical full frames needed to accept a press, and consecutive empty frames needed to accept a release; must be >= 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- col  out  4  one-hot column drive, active-high
- row  in  4  row returns, active-high; asynchronous to clk
- key_code  out  4  accepted key = col_idx*4 + row_idx (col 4'b0001 -> idx 0, 4'b1000 -> idx 3; row bit n -> idx n)
- key_valid  out  1  new key_code available; held until acked
- key_ack  in  1  consumer accepts key_code (effective only while key_valid=1)
- key_down  out  1  level: an accepted key is currently held
- overrun  out  1  sticky: a press was lost because key_valid was still pending

Behaviour:
- Reset (async, nrst=0): col=4'b1000, key_code=0, key_valid=0, key_down=0, overrun=0, divider=0, snapshot cleared, FSM=IDLE.
- row passes through a 2-flop synchroniser before use.
- Divider counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1 ("tick"), the synchronised row is stored into the 16-bit frame snapshot at the current column, and col shifts right; 4'b0001 wraps to 4'b1000.
- Frame completes on the tick of column 4'b0001. The snapshot is evaluated on that same tick, and a new frame starts empty.
- Frame classification:
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set, k = its code.
  - MULTI: >1 bit set. Treated as NONE for press detection and as "key present" for release detection.
- FSM, evaluated only on frame completion:
  - IDLE: SINGLE(k) -> cand=k, cnt=1; if DEBOUNCE=1 then ACCEPT, else DEB. Anything else stays in IDLE.
  - DEB: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE -> ACCEPT. SINGLE(other) -> cand=other, cnt=1. NONE/MULTI -> IDLE.
  - ACCEPT (action, same cycle): go to HELD, key_down=1, relcnt=0. If key_valid=0 or key_ack=1 this cycle: key_code=cand, key_valid=1. Otherwise: key_code unchanged, overrun=1.
  - HELD: NONE -> relcnt+1; relcnt reaches DEBOUNCE -> IDLE, key_down=0. SINGLE/MULTI -> relcnt=0.
- Handshake:
  - key_ack=1 with key_valid=1 clears key_valid and overrun on the next edge.
  - Ack in the same cycle as a new accept: the new key wins (key_valid stays 1, key_code updated), overrun cleared.
  - key_ack while key_valid=0 is ignored.
- Latency: a stable press is accepted DEBOUNCE frames after the first frame that sees it, plus at most 1 frame of phase alignment plus 2 cycles of sync. Each frame is 4*SCAN_DIV cycles.
- Outputs are registered; key_valid and key_code change on the same edge.
- Widths: divider $clog2(SCAN_DIV); cnt and relcnt $clog2(DEBOUNCE+1); all saturate-free because they reset on every state exit.
- nrst mid-scan or mid-debounce: immediate return to reset values; any pending key is discarded.

Decomposition:
- Package kbd_pkg: state enum (IDLE, DEB, HELD), NUM_COLS=4, NUM_ROWS=4, KEY_W=4, COL_RESET=4'b1000.
- Sub-module kbd_row_sync: 4-bit 2-flop synchroniser, async active-low reset to 0.
- All other logic lives in kbd_scan_4x4.

Test Plan (SCAN_DIV=4, DEBOUNCE=2):
- Reset then run: col sequence 1000,0100,0010,0001,1000, each held 4 cycles; all outputs 0.
- Drive row=4'b0010 only while col=4'b0100, held stable -> key_code=9 and key_valid=1 after 2 full frames; key_down=1. Pulse key_ack -> key_valid=0 next cycle. Remove key -> key_down=0 after 2 empty frames.
- Bounce: key 9 present for 1 frame, then absent -> key_valid never rises, FSM back to IDLE.
- Key 9 and key 0 (row=4'b0001 at col=4'b0001) held together -> no key_valid. While key 9 is HELD, adding a second key must not cause a release.
- Overrun: accept key 9 with no ack, release, then accept key 0 -> key_code stays 9, overrun=1. key_ack clears both key_valid and overrun.
- Assert nrst during DEB -> col=4'b1000 and all outputs 0 immediately. After release, key 9 needs 2 fresh frames to be accepted.
